// File: rtl/router_pkg.sv
// Shared definitions for the router packet checker.
//  - state_t        : packet FSM states
//  - PARITY_XOR/SUM : accumulator modes
//  - hdr_addr()     : destination address field of a header word
//  - hdr_len()      : payload length field of a header word
//  - acc_next()     : one accumulator step for either parity mode
// The helpers work on a wide word_t so one package serves every WIDTH;
// callers zero-extend their operands and cast the result back down.
package router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_PARITY  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int PARITY_XOR = 0;
  localparam int PARITY_SUM = 1;

  localparam int MAX_W = 64;
  typedef logic [MAX_W-1:0] word_t;

  function automatic word_t width_mask(input int width);
    if (width >= MAX_W) begin
      return {MAX_W{1'b1}};
    end else begin
      return (64'd1 << width) - 64'd1;
    end
  endfunction

  function automatic word_t hdr_addr(input word_t hdr, input int addr_bits);
    return hdr & width_mask(addr_bits);
  endfunction

  function automatic word_t hdr_len(input word_t hdr, input int addr_bits);
    return hdr >> addr_bits;
  endfunction

  // Additive mode must wrap at the data width, not at MAX_W.
  function automatic word_t acc_next(input word_t acc, input word_t word,
                                     input int width, input int mode);
    if (mode == PARITY_SUM) begin
      return (acc + word) & width_mask(width);
    end else begin
      return acc ^ word;
    end
  endfunction

endpackage

// File: rtl/router_out_slot.sv
// One-entry output register between the checker and the destination FIFO.
// Ports:
//  clock, resetn : clock and synchronous active-low reset
//  clear_i       : empty the slot (packet abort)
//  load_i        : capture data_i; wins over a same-cycle drain
//  drain_i       : the held word was written to the FIFO this cycle
//  data_i        : word to capture
//  valid_o       : slot holds a word
//  data_o        : held word
module router_out_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             drain_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // Slot register: load replaces a word being drained in the same cycle.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= {WIDTH{1'b0}};
    end else if (clear_i) begin
      valid_q <= 1'b0;
      data_q  <= {WIDTH{1'b0}};
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/router_pkt_checker.sv
// Packet register/checker between the router input port and the
// per-destination FIFOs. Decodes the header, forwards header, payload and
// parity words through a one-entry slot, and checks parity, length and
// destination address.
// Ports:
//  clock, resetn   : clock, synchronous active-low reset
//  soft_rst        : abort the current packet (slot, flags, dest, acc cleared)
//  pkt_valid       : 1 for header/payload words, 0 for the parity word
//  data_in         : input word
//  in_ready        : a word may be accepted this cycle
//  fifo_full       : selected destination FIFO is full
//  dout, out_we    : word and write strobe towards the FIFO
//  dest            : one-hot destination of the current packet
//  busy            : FSM not idle
//  parity_done     : one-cycle pulse at end of packet
//  err/len_err/addr_err : per-packet flags, held until next header accept
module router_pkt_checker
  import router_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ADDR_BITS   = 2,
  parameter int NUM_PORTS   = 3,
  parameter int PARITY_MODE = 0
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 soft_rst,
  input  logic                 pkt_valid,
  input  logic [WIDTH-1:0]     data_in,
  output logic                 in_ready,
  input  logic                 fifo_full,
  output logic [WIDTH-1:0]     dout,
  output logic                 out_we,
  output logic [NUM_PORTS-1:0] dest,
  output logic                 busy,
  output logic                 parity_done,
  output logic                 err,
  output logic                 len_err,
  output logic                 addr_err
);

  localparam int CW = WIDTH - ADDR_BITS;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [NUM_PORTS-1:0] dest_q, dest_d;
  logic                 err_q, err_d;
  logic                 len_err_q, len_err_d;
  logic                 addr_err_q, addr_err_d;
  logic                 busy_q, busy_d;
  logic                 parity_done_q, parity_done_d;

  logic                 slot_valid_s;
  logic [WIDTH-1:0]     slot_data_s;
  logic                 slot_load_s;
  logic                 in_ready_s;
  logic                 accept_s;
  logic [ADDR_BITS-1:0] hdr_addr_s;
  logic [CW-1:0]        hdr_len_s;
  logic                 addr_ok_s;
  logic [WIDTH-1:0]     acc_step_s;

  assign in_ready_s = (~slot_valid_s | ~fifo_full) & (state_q != ST_DONE);
  // In IDLE only a header (pkt_valid=1) starts a packet; soft_rst discards the word.
  assign accept_s   = in_ready_s & ~soft_rst & ((state_q != ST_IDLE) | pkt_valid);

  assign hdr_addr_s = ADDR_BITS'(hdr_addr(word_t'(data_in), ADDR_BITS));
  assign hdr_len_s  = CW'(hdr_len(word_t'(data_in), ADDR_BITS));
  assign addr_ok_s  = hdr_addr(word_t'(data_in), ADDR_BITS) < word_t'(NUM_PORTS);
  assign acc_step_s = WIDTH'(acc_next(word_t'(acc_q), word_t'(data_in), WIDTH, PARITY_MODE));

  // Next-state logic for the packet FSM, counter, accumulator and flags.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    dest_d      = dest_q;
    err_d       = err_q;
    len_err_d   = len_err_q;
    addr_err_d  = addr_err_q;
    slot_load_s = 1'b0;
    if (soft_rst) begin
      state_d    = ST_IDLE;
      cnt_d      = {CW{1'b0}};
      acc_d      = {WIDTH{1'b0}};
      dest_d     = {NUM_PORTS{1'b0}};
      err_d      = 1'b0;
      len_err_d  = 1'b0;
      addr_err_d = 1'b0;
    end else if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end else if (accept_s) begin
      case (state_q)
        ST_IDLE: begin
          acc_d       = data_in;
          cnt_d       = hdr_len_s;
          err_d       = 1'b0;
          len_err_d   = 1'b0;
          addr_err_d  = ~addr_ok_s;
          dest_d      = addr_ok_s ? (NUM_PORTS'(1'b1) << hdr_addr_s) : {NUM_PORTS{1'b0}};
          slot_load_s = addr_ok_s;
          state_d     = (hdr_len_s == {CW{1'b0}}) ? ST_PARITY : ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          slot_load_s = ~addr_err_q;
          if (pkt_valid) begin
            acc_d   = acc_step_s;
            cnt_d   = cnt_q - CW'(1'b1);
            state_d = (cnt_q == CW'(1'b1)) ? ST_PARITY : ST_PAYLOAD;
          end else begin
            // Early parity word: still checked, but the packet was short.
            err_d     = (data_in != acc_q);
            len_err_d = 1'b1;
            state_d   = ST_DONE;
          end
        end
        ST_PARITY: begin
          slot_load_s = ~addr_err_q;
          err_d       = (data_in != acc_q);
          len_err_d   = len_err_q | pkt_valid;
          state_d     = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    busy_d        = (state_d != ST_IDLE);
    parity_done_d = (state_d == ST_DONE);
  end

  // State and registered-output update.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      cnt_q         <= {CW{1'b0}};
      acc_q         <= {WIDTH{1'b0}};
      dest_q        <= {NUM_PORTS{1'b0}};
      err_q         <= 1'b0;
      len_err_q     <= 1'b0;
      addr_err_q    <= 1'b0;
      busy_q        <= 1'b0;
      parity_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      dest_q        <= dest_d;
      err_q         <= err_d;
      len_err_q     <= len_err_d;
      addr_err_q    <= addr_err_d;
      busy_q        <= busy_d;
      parity_done_q <= parity_done_d;
    end
  end

  router_out_slot #(.WIDTH(WIDTH)) u_slot (
    .clock   (clock),
    .resetn  (resetn),
    .clear_i (soft_rst),
    .load_i  (slot_load_s),
    .drain_i (slot_valid_s & ~fifo_full),
    .data_i  (data_in),
    .valid_o (slot_valid_s),
    .data_o  (slot_data_s)
  );

  assign in_ready    = in_ready_s;
  assign out_we      = slot_valid_s & ~fifo_full;
  assign dout        = slot_data_s;
  assign dest        = dest_q;
  assign busy        = busy_q;
  assign parity_done = parity_done_q;
  assign err         = err_q;
  assign len_err     = len_err_q;
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_router_pkt_checker.sv
// Bench for router_pkt_checker: one XOR-mode and one SUM-mode instance share
// all stimulus; a packet-level model supplies expected words and flags.
module tb_router_pkt_checker;

  logic       clock = 1'b0;
  logic       resetn, soft_rst, pkt_valid, fifo_full;
  logic [7:0] data_in;
  logic       in_ready0, in_ready1, out_we0, out_we1, busy0, busy1, pd0, pd1;
  logic       err0, err1, le0, le1, ae0, ae1;
  logic [7:0] dout0, dout1;
  logic [2:0] dest0, dest1;

  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pay_buf[8];
  int         ff_hold = 0;
  bit         ff_rand = 1'b0;

  always #5 clock = ~clock;

  router_pkt_checker #(.WIDTH(8), .ADDR_BITS(2), .NUM_PORTS(3), .PARITY_MODE(0)) u_xor (
    .clock(clock), .resetn(resetn), .soft_rst(soft_rst), .pkt_valid(pkt_valid),
    .data_in(data_in), .in_ready(in_ready0), .fifo_full(fifo_full), .dout(dout0),
    .out_we(out_we0), .dest(dest0), .busy(busy0), .parity_done(pd0), .err(err0),
    .len_err(le0), .addr_err(ae0));

  router_pkt_checker #(.WIDTH(8), .ADDR_BITS(2), .NUM_PORTS(3), .PARITY_MODE(1)) u_sum (
    .clock(clock), .resetn(resetn), .soft_rst(soft_rst), .pkt_valid(pkt_valid),
    .data_in(data_in), .in_ready(in_ready1), .fifo_full(fifo_full), .dout(dout1),
    .out_we(out_we1), .dest(dest1), .busy(busy1), .parity_done(pd1), .err(err1),
    .len_err(le1), .addr_err(ae1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Output stream monitor: every FIFO write must match the next expected word.
  always @(negedge clock) begin
    #2;
    if (out_we0 || out_we1) begin
      if (exp_q.size() == 0) begin
        check("spurious_write", {30'd0, out_we0, out_we1}, 32'd0);
      end else begin
        check("write_strobe", {30'd0, out_we0, out_we1}, 32'd3);
        check("dout_xor", {24'd0, dout0}, {24'd0, exp_q[0]});
        check("dout_sum", {24'd0, dout1}, {24'd0, exp_q[0]});
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic send_word(input logic [7:0] w, input logic v, output int stalls);
    bit accepted;
    accepted = 1'b0;
    stalls   = 0;
    for (int t = 0; t < 64 && !accepted; t++) begin
      @(negedge clock);
      data_in   = w;
      pkt_valid = v;
      if (ff_hold > 0) begin
        fifo_full = 1'b1;
        ff_hold--;
      end else if (ff_rand) begin
        fifo_full = ($urandom_range(0, 3) == 0);
      end else begin
        fifo_full = 1'b0;
      end
      #1;
      if (in_ready0 && in_ready1) accepted = 1'b1;
      else stalls++;
    end
    if (!accepted) check("accept_timeout", 32'd0, 32'd1);
  endtask

  // Drives one packet and checks flags at header accept, in DONE and after.
  task automatic run_pkt(input string name, input logic [7:0] hdr, input int k,
                         input logic [7:0] par, input logic par_v, input int stall_at);
    logic       legal, exp_le, ex0, ex1;
    logic [7:0] ax, as_;
    logic [2:0] dexp;
    int         len, st;
    legal = (hdr[1:0] < 2'd3);
    len   = int'(hdr[7:2]);
    dexp  = legal ? (3'b001 << hdr[1:0]) : 3'b000;
    ax    = hdr;
    as_   = hdr;
    send_word(hdr, 1'b1, st);
    if (legal) exp_q.push_back(hdr);
    else if (!ff_rand) check({name, "_drop_hdr_ready"}, st, 32'd0);
    @(posedge clock); #1;
    check({name, "_hdr_busy"}, {30'd0, busy0, busy1}, 32'd3);
    check({name, "_hdr_flags"}, {26'd0, err0, le0, ae0, err1, le1, ae1},
          {26'd0, 1'b0, 1'b0, ~legal, 1'b0, 1'b0, ~legal});
    check({name, "_hdr_dest"}, {26'd0, dest0, dest1}, {26'd0, dexp, dexp});
    for (int i = 0; i < k; i++) begin
      if (i == stall_at) ff_hold = 3;
      send_word(pay_buf[i], 1'b1, st);
      if (i == stall_at) check({name, "_stall_cycles"}, st, 32'd3);
      if (legal) exp_q.push_back(pay_buf[i]);
      else if (!ff_rand) check({name, "_drop_ready"}, st, 32'd0);
      ax  = ax ^ pay_buf[i];
      as_ = as_ + pay_buf[i];
    end
    send_word(par, par_v, st);
    if (legal) exp_q.push_back(par);
    exp_le = (k != len) || par_v;
    ex0    = (par != ax);
    ex1    = (par != as_);
    @(posedge clock); #1;
    pkt_valid = 1'b0;
    check({name, "_done_pulse"}, {30'd0, pd0, pd1}, 32'd3);
    check({name, "_done_ready"}, {30'd0, in_ready0, in_ready1}, 32'd0);
    check({name, "_err"}, {30'd0, err0, err1}, {30'd0, ex0, ex1});
    check({name, "_len_err"}, {30'd0, le0, le1}, {30'd0, exp_le, exp_le});
    check({name, "_addr_err"}, {30'd0, ae0, ae1}, {30'd0, ~legal, ~legal});
    check({name, "_done_dest"}, {26'd0, dest0, dest1}, {26'd0, dexp, dexp});
    @(posedge clock); #1;
    check({name, "_idle"}, {28'd0, busy0, busy1, pd0, pd1}, 32'd0);
    check({name, "_held"}, {26'd0, err0, le0, ae0, err1, le1, ae1},
          {26'd0, ex0, exp_le, ~legal, ex1, exp_le, ~legal});
  endtask

  // Aborts a packet after header+one payload, with the payload stuck in the slot.
  task automatic abort_mid(input bit use_rst);
    int st;
    send_word(8'h0D, 1'b1, st);
    exp_q.push_back(8'h0D);
    send_word(8'h11, 1'b1, st);
    exp_q.push_back(8'h11);
    @(negedge clock);
    soft_rst  = ~use_rst;
    resetn    = ~use_rst;
    fifo_full = 1'b1;
    data_in   = 8'h22;
    void'(exp_q.pop_back());
    @(negedge clock);
    soft_rst  = 1'b0;
    resetn    = 1'b1;
    fifo_full = 1'b0;
    pkt_valid = 1'b0;
    #1;
    check(use_rst ? "rst_busy" : "srst_busy", {30'd0, busy0, busy1}, 32'd0);
    check(use_rst ? "rst_slot" : "srst_slot", {30'd0, out_we0, out_we1}, 32'd0);
    check(use_rst ? "rst_flags" : "srst_flags",
          {24'd0, err0, le0, ae0, pd0, err1, le1, ae1, pd1}, 32'd0);
    check(use_rst ? "rst_dest" : "srst_dest", {26'd0, dest0, dest1}, 32'd0);
    check(use_rst ? "rst_ready" : "srst_ready", {30'd0, in_ready0, in_ready1}, 32'd3);
  endtask

  task automatic load_t1;
    pay_buf[0] = 8'h11;
    pay_buf[1] = 8'h22;
    pay_buf[2] = 8'h33;
  endtask

  initial begin
    logic [5:0] len6;
    logic [1:0] addr2;
    logic [7:0] hdr, ax, as_, par;
    int         k, sel;
    bit         short_pkt;
    logic       pv;

    resetn = 1'b0; soft_rst = 1'b0; pkt_valid = 1'b0; fifo_full = 1'b0; data_in = 8'h00;
    repeat (3) @(negedge clock);
    #1;
    check("reset_outs", {16'd0, busy0, busy1, pd0, pd1, err0, err1, le0, le1, ae0, ae1,
                         out_we0, out_we1, 4'd0}, 32'd0);
    check("reset_dest", {26'd0, dest0, dest1}, 32'd0);
    check("reset_dout", {16'd0, dout0, dout1}, 32'd0);
    resetn = 1'b1;
    @(negedge clock); #1;
    check("idle_ready", {30'd0, in_ready0, in_ready1}, 32'd3);

    load_t1();
    run_pkt("t1", 8'h0D, 3, 8'h0D, 1'b0, -1);
    run_pkt("t2", 8'h0D, 3, 8'hFF, 1'b0, -1);
    run_pkt("t3", 8'h0D, 3, 8'h0D, 1'b0, 1);
    pay_buf[0] = 8'h5A;
    run_pkt("t4", 8'h07, 1, 8'h5D, 1'b0, -1);
    pay_buf[0] = 8'h11;
    run_pkt("t5", 8'h0D, 1, 8'h1C, 1'b0, -1);
    abort_mid(1'b0);
    load_t1();
    run_pkt("t6_srst", 8'h0D, 3, 8'h0D, 1'b0, -1);
    abort_mid(1'b1);
    run_pkt("t6_rst", 8'h0D, 3, 8'h0D, 1'b0, -1);
    pay_buf[0] = 8'hFF;
    run_pkt("t7", 8'h05, 1, 8'h04, 1'b0, -1);
    run_pkt("len0", 8'h02, 0, 8'h02, 1'b0, -1);
    load_t1();
    run_pkt("overrun", 8'h0D, 3, 8'h0D, 1'b1, -1);

    ff_rand = 1'b1;
    for (int p = 0; p < 40; p++) begin
      len6      = 6'($urandom_range(0, 5));
      addr2     = 2'($urandom_range(0, 3));
      hdr       = {len6, addr2};
      short_pkt = (len6 != 6'd0) && ($urandom_range(0, 4) == 0);
      k         = short_pkt ? int'($urandom_range(0, int'(len6) - 1)) : int'(len6);
      ax        = hdr;
      as_       = hdr;
      for (int i = 0; i < k; i++) begin
        pay_buf[i] = 8'($urandom_range(0, 255));
        ax         = ax ^ pay_buf[i];
        as_        = as_ + pay_buf[i];
      end
      sel = int'($urandom_range(0, 2));
      par = (sel == 0) ? ax : ((sel == 1) ? as_ : 8'($urandom_range(0, 255)));
      pv  = (!short_pkt) && ($urandom_range(0, 5) == 0);
      run_pkt("rnd", hdr, k, par, pv, -1);
    end

    ff_rand = 1'b0;
    @(negedge clock);
    fifo_full = 1'b0;
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clock);
    #3;
    check("drain_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
